// File: rtl/multicycle_addsub.sv
// ----------------------------------------------------------------------------
// multicycle_addsub
//   WIDTH-bit two's-complement adder/subtractor that handles CHUNK bits per
//   clock. A registered carry links the chunks, so the adder itself is only
//   CHUNK bits wide. One operation takes N = WIDTH/CHUNK RUN cycles.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   start            request, sampled only while idle
//   subtract         0: A+B, 1: A-B (latched with start)
//   A, B             operands (latched with start)
//   busy             operation in progress
//   done             one-cycle pulse, Result and flags valid
//   Result           sum/difference, held until the next operation completes
//   Cout             carry out of MSB (subtract: 1 = no borrow)
//   Overflow         signed overflow
//   Zero, Negative   Result == 0, Result[WIDTH-1]
//
// state | meaning
// ------+--------------------------------------------------
// IDLE  | waiting for start; Result and flags hold
// RUN   | one chunk per cycle, chunk index idx counts up to N-1
// ----------------------------------------------------------------------------
module multicycle_addsub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             subtract,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Result,
    output logic             Cout,
    output logic             Overflow,
    output logic             Zero,
    output logic             Negative
);

    localparam int N  = WIDTH / CHUNK;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]       state;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;      // already inverted for subtraction
    logic [WIDTH-1:0] part_r;
    logic             carry_r;

    int               lsb;
    logic [CHUNK-1:0] a_ch;
    logic [CHUNK-1:0] b_ch;
    logic [CHUNK:0]   ch_sum;
    logic [WIDTH-1:0] merged;
    logic             msb_cin;
    logic             last;

    always_comb begin
        lsb     = int'(idx) * CHUNK;
        a_ch    = a_r[lsb +: CHUNK];
        b_ch    = b_r[lsb +: CHUNK];
        ch_sum  = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, carry_r};
        merged  = part_r;
        merged[lsb +: CHUNK] = ch_sum[CHUNK-1:0];
        // Carry into the MSB recovered from the sum bit: s = a ^ b ^ cin.
        // Only meaningful on the last chunk, which is the only time it is used.
        msb_cin = a_r[WIDTH-1] ^ b_r[WIDTH-1] ^ ch_sum[CHUNK-1];
        last    = (idx == IW'(N - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            a_r      <= '0;
            b_r      <= '0;
            part_r   <= '0;
            carry_r  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            Result   <= '0;
            Cout     <= 1'b0;
            Overflow <= 1'b0;
            Zero     <= 1'b0;
            Negative <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r     <= A;
                        b_r     <= subtract ? ~B : B;
                        carry_r <= subtract;
                        part_r  <= '0;
                        idx     <= '0;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    part_r  <= merged;
                    carry_r <= ch_sum[CHUNK];
                    if (last) begin
                        Result   <= merged;
                        Cout     <= ch_sum[CHUNK];
                        Overflow <= msb_cin ^ ch_sum[CHUNK];
                        Zero     <= (merged == '0);
                        Negative <= merged[WIDTH-1];
                        idx      <= '0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_addsub.sv
module tb_multicycle_addsub;

    localparam int W = 16;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         subtract = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         busy, done, Cout, Overflow, Zero, Negative;
    logic [W-1:0] Result;

    logic         start8 = 1'b0;
    logic         sub8 = 1'b0;
    logic [7:0]   a8 = '0;
    logic [7:0]   b8 = '0;
    logic         busy8, done8, cout8, ovf8, zero8, neg8;
    logic [7:0]   res8;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    multicycle_addsub #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .subtract(subtract),
        .A(A), .B(B), .busy(busy), .done(done), .Result(Result),
        .Cout(Cout), .Overflow(Overflow), .Zero(Zero), .Negative(Negative)
    );

    multicycle_addsub #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .subtract(sub8),
        .A(a8), .B(b8), .busy(busy8), .done(done8), .Result(res8),
        .Cout(cout8), .Overflow(ovf8), .Zero(zero8), .Negative(neg8)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Arithmetic reference: {carry, signed overflow, result}
    function automatic logic [W+1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic sub);
        logic [W-1:0] bb;
        logic [W:0]   full;
        logic         v;
        bb   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + (W+1)'(sub);
        v    = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
        return {full[W], v, full[W-1:0]};
    endfunction

    // Timeline model: an accepted request completes N edges later; the
    // block accepts again at the edge after completion.
    int           m_pend = 0;
    logic [W-1:0] m_a, m_b;
    logic         m_sub;
    logic         m_busy = 0, m_done = 0, m_c = 0, m_v = 0, m_z = 0, m_n = 0;
    logic [W-1:0] m_res = '0;

    always @(posedge clk) begin
        logic [W+1:0] r;
        if (!rst_n) begin
            m_pend = 0; m_busy = 0; m_done = 0; m_res = '0;
            m_c = 0; m_v = 0; m_z = 0; m_n = 0;
        end else begin
            m_done = 0;
            if (m_pend == 0) begin
                if (start) begin
                    m_a = A; m_b = B; m_sub = subtract;
                    m_pend = N; m_busy = 1;
                end
            end else begin
                m_pend--;
                if (m_pend == 0) begin
                    r = ref_op(m_a, m_b, m_sub);
                    m_res = r[W-1:0]; m_v = r[W]; m_c = r[W+1];
                    m_z = (m_res == '0); m_n = m_res[W-1];
                    m_busy = 0; m_done = 1;
                end
            end
        end
        #1;
        chk("busy", busy, m_busy);
        chk("done", done, m_done);
        chk("result", Result, m_res);
        chk("cout", Cout, m_c);
        chk("overflow", Overflow, m_v);
        chk("zero", Zero, m_z);
        chk("negative", Negative, m_n);
    end

    // Directed op with hand-computed expectations, latency and busy length.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                         input logic [W-1:0] er, input logic ec, input logic ev,
                         input logic ez, input logic en);
        int lat = -1;
        int bcnt = 0;
        @(negedge clk);
        A = a; B = b; subtract = sub; start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #2;
            if (i == 0) start = 1'b0;
            if (done) begin lat = i; break; end
            if (busy) bcnt++;
        end
        chk("latency", lat, N);
        chk("busy_len", bcnt, N);
        chk("lit_result", Result, er);
        chk("lit_cout", Cout, ec);
        chk("lit_ovf", Overflow, ev);
        chk("lit_zero", Zero, ez);
        chk("lit_neg", Negative, en);
        @(posedge clk); #2;
        chk("done_pulse_len", done, 1'b0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        do_op(16'h1234, 16'h0FF1, 1'b0, 16'h2225, 0, 0, 0, 0);
        do_op(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 0, 0, 0, 1);
        do_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 0, 1, 0, 1);
        do_op(16'h8000, 16'h8000, 1'b1, 16'h0000, 1, 0, 1, 0);

        // start held high with operands churning every cycle
        begin
            int ndone = 0;
            @(negedge clk);
            start = 1'b1;
            for (int i = 0; i < 25; i++) begin
                A = W'($urandom); B = W'($urandom); subtract = 1'($urandom);
                @(negedge clk);
                if (done) ndone++;
            end
            start = 1'b0;
            chk("held_start_done_count", ndone, 5);
        end
        repeat (6) @(negedge clk);

        // reset two cycles into an operation
        A = 16'h1111; B = 16'h2222; subtract = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); rst_n = 1'b0;
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_result", Result, 16'h0000);
        @(negedge clk); rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("rst_no_done", done, 1'b0);
        end
        do_op(16'h1234, 16'h0FF1, 1'b0, 16'h2225, 0, 0, 0, 0);

        // random stimulus against the model
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 2) == 0);
            A = W'($urandom); B = W'($urandom); subtract = 1'($urandom);
            if ((i % 8) == 0) begin
                A = (i % 16 == 0) ? 16'h8000 : 16'h7FFF;
                B = A;
            end
        end
        @(negedge clk); start = 1'b0;
        repeat (8) @(negedge clk);

        // CHUNK == WIDTH instance
        a8 = 8'hFF; b8 = 8'h01; sub8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #2;
        start8 = 1'b0;
        chk("w8_busy", busy8, 1'b1);
        chk("w8_done_early", done8, 1'b0);
        @(posedge clk); #2;
        chk("w8_done", done8, 1'b1);
        chk("w8_result", res8, 8'h00);
        chk("w8_cout", cout8, 1'b1);
        chk("w8_zero", zero8, 1'b1);
        chk("w8_ovf", ovf8, 1'b0);
        chk("w8_busy_after", busy8, 1'b0);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
